pc_fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly downstream of the next-PC logic: holds the architectural fetch PC, takes redirect targets computed by the next-PC block, issues word requests to instruction memory and buffers returned instructions (tagged with their PC) for decode. Supports up to two requests in flight, an in-order 2-entry output buffer, downstream back-pressure and flush-on-redirect with discard of stale responses.

---
 rtl/pc_fetch_unit_if.sv | 26 ++
 rtl/pc_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: redirect input, instruction-memory request/response,
// and the decode-side output buffer head.
interface pc_fetch_unit_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_adef;

    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_inst, if_pc, if_adef
    );

    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_inst, if_pc, if_adef
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: up to two imem requests in flight, 2-entry in-order output buffer,
// flush on redirect. Define PC_FETCH_ALIGN_CHECK_EN to fault on misaligned redirect targets.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_fetch_unit_if.master bus
);
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adef;
    } fetch_ent_t;

    logic [31:0] pc_q, pc_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [1:0]  discard_q, discard_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] tag_q [2];
    logic [31:0] tag_d [2];
    fetch_ent_t  buf_q [2];
    fetch_ent_t  buf_d [2];

    logic [1:0]  live;
    logic [2:0]  credit;
    logic        pop, req, gnt_fire, resp, keep;
    logic        tag_widx, buf_widx;
    logic        halt, adef_push, redir_bad;
    logic [31:0] adef_pc;

`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic        halt_q, halt_d;
    logic        pend_q, pend_d;
    logic [31:0] adef_pc_q, adef_pc_d;

    assign redir_bad = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
    assign halt      = halt_q;
    assign adef_pc   = adef_pc_q;
    // Fault entry is injected only once every stale response has been dropped.
    assign adef_push = pend_q && (discard_q == 2'd0) && !bus.redirect;

    always_comb begin
        halt_d    = halt_q;
        pend_d    = pend_q;
        adef_pc_d = adef_pc_q;
        if (bus.redirect) begin
            halt_d    = redir_bad;
            pend_d    = redir_bad;
            adef_pc_d = bus.redirect_pc;
        end else if (adef_push) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q    <= 1'b0;
            pend_q    <= 1'b0;
            adef_pc_q <= '0;
        end else begin
            halt_q    <= halt_d;
            pend_q    <= pend_d;
            adef_pc_q <= adef_pc_d;
        end
    end
`else
    assign redir_bad = 1'b0;
    assign halt      = 1'b0;
    assign adef_push = 1'b0;
    assign adef_pc   = '0;
`endif

    assign live     = inflight_q - discard_q;
    assign pop      = (cnt_q != 2'd0) && bus.if_ready;
    // Credit counts every slot a granted request may still need in the buffer.
    assign credit   = {1'b0, live} + {1'b0, cnt_q} - {2'b00, pop};
    assign req      = !bus.redirect && !halt && (inflight_q < 2'd2) && (credit < 3'd2);
    assign gnt_fire = req && bus.imem_gnt;
    assign resp     = bus.imem_rvalid && (inflight_q != 2'd0);
    assign keep     = resp && (discard_q == 2'd0);
    assign tag_widx = (inflight_q != 2'd0) && !resp;
    assign buf_widx = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);

    always_comb begin
        pc_d       = pc_q;
        discard_d  = discard_q;
        tag_d      = tag_q;
        buf_d      = buf_q;
        inflight_d = inflight_q + {1'b0, gnt_fire} - {1'b0, resp};
        cnt_d      = cnt_q - {1'b0, pop} + {1'b0, keep || adef_push};

        if (resp)
            tag_d[0] = tag_q[1];
        if (gnt_fire) begin
            tag_d[tag_widx] = pc_q;
            pc_d            = pc_q + 32'd4;
        end
        if (resp && (discard_q != 2'd0))
            discard_d = discard_q - 2'd1;

        if (pop)
            buf_d[0] = buf_q[1];
        if (keep)
            buf_d[buf_widx] = '{inst: bus.imem_rdata, pc: tag_q[0], adef: 1'b0};
        else if (adef_push)
            buf_d[buf_widx] = '{inst: 32'h0, pc: adef_pc, adef: 1'b1};

        // Redirect wins: everything younger is flushed, in-flight responses become stale.
        if (bus.redirect) begin
            pc_d      = redir_bad ? pc_q : (bus.redirect_pc & 32'hFFFF_FFFC);
            cnt_d     = 2'd0;
            discard_d = inflight_q - {1'b0, resp};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 2'd0;
            discard_q  <= 2'd0;
            cnt_q      <= 2'd0;
            tag_q[0]   <= '0;
            tag_q[1]   <= '0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            buf_q      <= buf_d;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = (cnt_q != 2'd0);
    assign bus.if_inst   = buf_q[0].inst;
    assign bus.if_pc     = buf_q[0].pc;
    assign bus.if_adef   = buf_q[0].adef;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: in-order memory model with variable latency, expected-entry
// queue filled at grant time, vector table of redirect scenarios plus hand sequences.
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_unit_if bus();
    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adef;
    } exp_t;
    typedef struct {
        logic [31:0] tgt;
        int          lat;
        bit          rnd;
        logic [31:0] e0, e1, e2;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mem_lat = 1;
    bit gnt_en = 1'b0;
    bit rdy = 1'b1;
    bit rand_rdy = 1'b0;
    bit do_redir = 1'b0;
    bit halt_m = 1'b0;
    int req_in_halt = 0;
    int max_occ = 0;
    int first_g = -1;
    int first_p = -1;
    logic [31:0] redir_pc = '0;
    logic [31:0] model_pc = '0;
    logic s_req, s_valid;
    logic [31:0] s_addr;
    mreq_t mq[$];
    exp_t exp_q[$];
    logic [31:0] popped[$];
    vec_t vecs[5];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pc_at(input int i);
        return (popped.size() > i) ? popped[i] : 32'hBAD0_BAD0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic cycle();
        logic g, p;
        exp_t e;
        bus.imem_gnt    = gnt_en;
        bus.if_ready    = rand_rdy ? 1'($urandom_range(0, 1)) : rdy;
        bus.redirect    = do_redir;
        bus.redirect_pc = redir_pc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = inst_of(mq[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
        #1;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.if_valid;
        g = s_req && bus.imem_gnt && rst_n;
        p = s_valid && bus.if_ready && rst_n;
        if (bus.imem_rvalid) void'(mq.pop_front());
        if (halt_m && s_req) req_in_halt++;
        if (do_redir) begin
            chk("req_during_redirect", {31'b0, s_req}, 32'd0);
            exp_q.delete();
`ifdef PC_FETCH_ALIGN_CHECK_EN
            if (redir_pc[1:0] != 2'b00) begin
                halt_m = 1'b1;
                exp_q.push_back('{inst: 32'h0, pc: redir_pc, adef: 1'b1});
            end else begin
                halt_m   = 1'b0;
                model_pc = redir_pc;
            end
`else
            model_pc = redir_pc & 32'hFFFF_FFFC;
`endif
        end else begin
            if (p) begin
                if (first_p < 0) first_p = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected: got pc %h expected no entry", bus.if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", bus.if_pc, e.pc);
                    chk("pop_inst", bus.if_inst, e.inst);
                    chk("pop_adef", {31'b0, bus.if_adef}, {31'b0, e.adef});
                end
                popped.push_back(bus.if_pc);
            end
            if (g) begin
                if (first_g < 0) first_g = cyc;
                chk("grant_addr", s_addr, model_pc);
                exp_q.push_back('{inst: inst_of(model_pc), pc: model_pc, adef: 1'b0});
                mq.push_back('{addr: s_addr, due: cyc + mem_lat});
                model_pc = model_pc + 32'd4;
            end
            if (exp_q.size() > max_occ) max_occ = exp_q.size();
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        do_redir = 1'b1;
        redir_pc = tgt;
        cycle();
        do_redir = 1'b0;
    endtask

    task automatic run_until(input int n, input int bound, input string name);
        int k = 0;
        while (popped.size() < n && k < bound) begin
            cycle();
            k++;
        end
        if (popped.size() < n) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d pops expected %0d", name, popped.size(), n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{tgt: 32'h0000_0100, lat: 1, rnd: 1'b0, e0: 32'h100, e1: 32'h104, e2: 32'h108};
        vecs[1] = '{tgt: 32'hFFFF_FFF8, lat: 1, rnd: 1'b0, e0: 32'hFFFF_FFF8, e1: 32'hFFFF_FFFC, e2: 32'h0};
        vecs[2] = '{tgt: 32'h0000_2000, lat: 2, rnd: 1'b0, e0: 32'h2000, e1: 32'h2004, e2: 32'h2008};
        vecs[3] = '{tgt: 32'h0000_3000, lat: 3, rnd: 1'b1, e0: 32'h3000, e1: 32'h3004, e2: 32'h3008};
        vecs[4] = '{tgt: 32'hFFFF_FFFC, lat: 2, rnd: 1'b1, e0: 32'hFFFF_FFFC, e1: 32'h0, e2: 32'h4};

        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.if_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_req", {31'b0, bus.imem_req}, 32'd1);
        chk("reset_addr", bus.imem_addr, 32'h0);
        chk("reset_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("reset_inst", bus.if_inst, 32'h0);
        chk("reset_pc", bus.if_pc, 32'h0);
        chk("reset_adef", {31'b0, bus.if_adef}, 32'd0);

        // streaming with single-cycle memory
        gnt_en = 1'b1; mem_lat = 1; rdy = 1'b1;
        repeat (25) cycle();
        chk("first_latency", first_p - first_g, 32'd2);
        chk("stream_pc0", pc_at(0), 32'h0);
        chk("stream_pc1", pc_at(1), 32'h4);
        chk("stream_pc2", pc_at(2), 32'h8);
        chk("throughput", popped.size(), 32'd23);

        // back-pressure
        rdy = 1'b0; max_occ = 0;
        repeat (5) cycle();
        chk("bp_occupancy", max_occ, 32'd2);
        chk("bp_req_stopped", {31'b0, s_req}, 32'd0);
        rdy = 1'b1; popped.delete();
        run_until(6, 40, "bp_release");
        chk("bp_resume_pc", pc_at(5) - pc_at(0), 32'd20);

        // redirect with two requests in flight
        mem_lat = 3;
        begin
            int k = 0;
            while (mq.size() != 2 && k < 20) begin cycle(); k++; end
        end
        chk("two_inflight", mq.size(), 32'd2);
        popped.delete();
        redirect_to(32'h0000_0100);
        run_until(2, 30, "redir_inflight");
        chk("redir_inflight_pc0", pc_at(0), 32'h100);
        chk("redir_inflight_pc1", pc_at(1), 32'h104);

        // redirect coinciding with a response and a pop
        mem_lat = 1;
        repeat (6) cycle();
        chk("rvalid_at_redirect", {31'b0, (mq.size() > 0 && mq[0].due <= cyc)}, 32'd1);
        popped.delete();
        redirect_to(32'h0000_0500);
        cycle();
        chk("redir_valid_low", {31'b0, s_valid}, 32'd0);
        chk("redir_req_next", {31'b0, s_req}, 32'd1);
        chk("redir_addr_next", s_addr, 32'h500);
        run_until(2, 30, "redir_rvalid");
        chk("redir_rvalid_pc0", pc_at(0), 32'h500);
        chk("redir_rvalid_pc1", pc_at(1), 32'h504);

        // vector table of redirect targets, latencies and ready patterns
        for (int i = 0; i < 5; i++) begin
            mem_lat = vecs[i].lat;
            rand_rdy = vecs[i].rnd;
            popped.delete();
            redirect_to(vecs[i].tgt);
            run_until(3, 80, "vec");
            chk($sformatf("vec%0d_pc0", i), pc_at(0), vecs[i].e0);
            chk($sformatf("vec%0d_pc1", i), pc_at(1), vecs[i].e1);
            chk($sformatf("vec%0d_pc2", i), pc_at(2), vecs[i].e2);
            repeat (2) cycle();
        end
        rand_rdy = 1'b0;

        // reset while requests are outstanding
        mem_lat = 2;
        repeat (4) cycle();
        rst_n = 1'b0; gnt_en = 1'b0;
        exp_q.delete(); model_pc = 32'h0; halt_m = 1'b0;
        repeat (3) cycle();
        chk("midrst_valid", {31'b0, s_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (2) cycle();
        chk("midrst_req", {31'b0, s_req}, 32'd1);
        chk("midrst_addr", s_addr, 32'h0);
        gnt_en = 1'b1; popped.delete();
        run_until(2, 30, "midrst");
        chk("midrst_pc0", pc_at(0), 32'h0);
        chk("midrst_pc1", pc_at(1), 32'h4);

        // misaligned redirect target
        mem_lat = 1;
        repeat (3) cycle();
        popped.delete();
        redirect_to(32'h0000_0102);
`ifdef PC_FETCH_ALIGN_CHECK_EN
        req_in_halt = 0;
        repeat (10) cycle();
        chk("adef_count", popped.size(), 32'd1);
        chk("adef_pc", pc_at(0), 32'h102);
        chk("adef_no_req", req_in_halt, 32'd0);
        popped.delete();
        redirect_to(32'h0000_0200);
        run_until(1, 30, "adef_recover");
        chk("adef_recover_pc", pc_at(0), 32'h200);
`else
        run_until(2, 30, "misalign");
        chk("misalign_pc0", pc_at(0), 32'h100);
        chk("misalign_pc1", pc_at(1), 32'h104);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
